// File: rtl/fifo_uart_tx.sv
// Word FIFO feeding the UART transmitter: 32-bit words are buffered and
// emitted MSB-first as bytes over a valid/ready handshake.
//
// state | meaning
// IDLE  | output stage empty, waiting for a queued word
// SEND  | presenting shreg's top byte, advancing on each handshake
module fifo_uart_tx #(
  parameter int DEPTH     = 4,
  parameter int WIDTH_IN  = 32,
  parameter int WIDTH_OUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH_IN-1:0]      data_in,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [WIDTH_OUT-1:0]     tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH_IN-1:0] mem [DEPTH];
  // Pointers wrap naturally over the power-of-two depth; count alone
  // distinguishes full from empty.
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [WIDTH_IN-1:0] shreg;
  logic [1:0]          byte_idx;
  logic                wr_ok, pop, shift, clear, hs;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign wr_ok   = wr_en & ~full;
  assign hs      = tx_valid & tx_ready;
  assign tx_data = shreg[WIDTH_IN-1 -: WIDTH_OUT];

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    busy     = 1'b0;
    pop      = 1'b0;
    shift    = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (hs) begin
          if (byte_idx != 2'd3) begin
            shift = 1'b1;
          end else if (!empty) begin
            // back-to-back words: reload without an idle bubble
            pop = 1'b1;
          end else begin
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (pop) begin
      shreg    <= mem[rd_ptr];
      byte_idx <= '0;
    end else if (shift) begin
      shreg    <= shreg << WIDTH_OUT;
      byte_idx <= byte_idx + 2'd1;
    end else if (clear) begin
      shreg    <= '0;
    end
  end

endmodule
